uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Receive side of the 4-byte UART framing link: sync byte 0x7B, then payload bytes [23:16], [15:8], [7:0].
- Deserialises 8N1 bytes from a single rx pin and reassembles the 24-bit word.
- Presents the word with a one-cycle valid strobe.
- Sits at the host-to-FPGA boundary, mirroring the TX framer on the other link end.

Parameters:
- CLKS_PER_BIT, 40, clk_20m cycles per UART bit (20 MHz / 500 kbit/s); must be ≥ 8.
- SYNC_BYTE, 8'h7B, frame header value (decimal 123).
- TIMEOUT_BITS, 20, max idle gap in bit periods between bytes of one frame.

Ports:
- clk_20m  in  1  system clock, 20 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idle high, asynchronous to clk_20m.
- data  out  24  last complete payload, byte order [23:16],[15:8],[7:0].
- data_rdy  out  1  one-cycle strobe: data updated this cycle.
- frame_err  out  1  one-cycle strobe: frame aborted (bad stop bit or timeout).
- busy  out  1  high while a frame is past the sync byte (states B2/B1/B0).

Behaviour:
- Reset (rst_n low, async):
  - data = 0, data_rdy = 0, frame_err = 0, busy = 0.
  - Synchroniser flops = 1; byte receiver IDLE; frame FSM HUNT; all counters 0.
- Input sync: rx passes through 2 flops (rx_s) before any use.
- Byte receiver states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s == 0 → START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1, sample rx_s.
    - Sample 1 → glitch; return to IDLE, no strobe.
    - Sample 0 → DATA.
  - DATA: sample every CLKS_PER_BIT cycles at bit centre; 8 bits, LSB first, shifted into an 8-bit register.
  - STOP: sample at centre.
    - rx_s == 1 → byte_valid pulse for 1 cycle; go to IDLE.
    - rx_s == 0 → byte_err pulse; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. A held-low line (break) never produces bytes.
- Frame FSM states: HUNT, B2, B1, B0.
  - HUNT: byte_valid with byte == SYNC_BYTE → B2. Any other byte is discarded silently, no frame_err.
  - B2: byte_valid → hold[23:16] = byte, go to B1.
  - B1: byte_valid → hold[15:8] = byte, go to B0.
  - B0: byte_valid → data = {hold[23:8], byte} and data_rdy = 1, both on the next clk edge; go to HUNT.
- Positional framing: a payload byte equal to 0x7B is data, never a resync.
- data_rdy latency: 1 clk after byte_valid. byte_valid fires 1 clk after the stop-bit centre sample.
- data holds its value until the next complete frame; it is never changed by an aborted frame.
- Error handling:
  - byte_err in B2/B1/B0 → HUNT with a frame_err pulse.
  - byte_err in HUNT → no frame_err.
- Timeout:
  - A gap counter runs in B2/B1/B0 while the byte receiver is IDLE.
  - It clears on every byte_valid.
  - At TIMEOUT_BITS*CLKS_PER_BIT cycles → HUNT with a frame_err pulse.
  - Not active in HUNT.
- Simultaneous events: byte_valid and timeout never coincide (the counter only runs in IDLE). byte_err takes priority over everything else.
- data_rdy and frame_err are never high in the same cycle.
- busy = (state != HUNT), registered.
- Reset mid-frame discards the partial frame; data returns to 0.

Decomposition:
- Shared package (uart_link_pkg):
  - SYNC_BYTE constant, shared with the TX framer.
  - FRAME_BYTES = 4.
  - Frame-state enum {HUNT, B2, B1, B0}.
- Sub-module uart_rx_byte holds the synchroniser and byte receiver.
  - Ports: clk_20m, rst_n, rx, byte_out[7:0], byte_valid, byte_err.
  - Parameter: CLKS_PER_BIT.
- uart_frame_rx contains the frame FSM, hold register and timeout counter.

Test Plan:
- Bytes 0x7B,0x12,0x34,0x56 at 500 kbit/s → one data_rdy pulse, data = 24'h123456, frame_err never high, busy high from the end of the sync byte to the end of the last byte.
- Bytes 0x55,0xAA then 0x7B,0x7B,0x00,0x7B → 0x55/0xAA ignored, no frame_err; data = 24'h7B007B, one data_rdy.
- 0x7B,0x01 then rx idle for 25 bit periods → frame_err pulse at exactly 20*40 cycles after the 0x01 byte_valid; busy drops; data unchanged.
- 0x7B,0x01 then a byte with stop bit forced 0 → frame_err, state HUNT; a following full frame 0x7B,0xDE,0xAD,0xBE → data = 24'hDEADBE.
- 0.5-bit (20-cycle) low glitch on idle rx → no byte_valid, no strobes; a 0x7B sent next is still accepted.
- rst_n asserted mid-frame, between byte 2 and byte 3 → outputs 0 immediately (async); after release, a fresh frame 0x7B,0xAB,0xCD,0xEF → data = 24'hABCDEF.

Source files
------------

// File: rtl/uart_link_pkg.sv
// Definitions shared by both ends of the 4-byte UART framing link
// (sync byte followed by a 24-bit payload, MSB byte first).
package uart_link_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'h7B;
  localparam int unsigned FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    HUNT,
    B2,
    B1,
    B0
  } frame_state_t;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Serial input and reassembled-word outputs of the frame receiver.
interface uart_frame_rx_if;

  logic        rx;
  logic [23:0] data;
  logic        data_rdy;
  logic        frame_err;
  logic        busy;

  modport master (input rx, output data, output data_rdy, output frame_err, output busy);
  modport slave  (output rx, input data, input data_rdy, input frame_err, input busy);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop input synchroniser, centre sampling,
// glitch rejection on the start bit and break hold-off after a bad stop bit.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 40
) (
  input  logic       clk_20m,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       rx_idle
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  assign rx_s    = sync[1];
  assign rx_idle = (state == S_IDLE);

  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          // Half a bit in: a line back high here was only a glitch.
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            byte_out <= {rx_s, byte_out[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              state      <= S_IDLE;
            end else begin
              byte_err <= 1'b1;
              state    <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: hunts for the sync byte, assembles three payload bytes
// positionally and aborts on a bad stop bit or an over-long inter-byte gap.
module uart_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 40,
  parameter logic [7:0]  SYNC_BYTE    = uart_link_pkg::SYNC_BYTE,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input logic             clk_20m,
  input logic             rst_n,
  uart_frame_rx_if.master link
);

  import uart_link_pkg::*;

  localparam int unsigned   TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned   GW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST       = GW'(TIMEOUT_CYCLES - 1);

  logic [7:0]   byte_val;
  logic         byte_valid;
  logic         byte_err;
  logic         rx_idle;
  frame_state_t state;
  frame_state_t state_nxt;
  logic [15:0]  hold;
  logic [GW-1:0] gap;
  logic         timeout;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk_20m   (clk_20m),
    .rst_n     (rst_n),
    .rx        (link.rx),
    .byte_out  (byte_val),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .rx_idle   (rx_idle)
  );

  // gap is loaded with 1 on byte_valid so it equals cycles elapsed since then.
  assign timeout = (state != HUNT) && rx_idle && (gap == GAP_LAST);

  always_comb begin
    state_nxt = state;
    if (byte_err) begin
      state_nxt = HUNT;
    end else if (byte_valid) begin
      case (state)
        HUNT:    if (byte_val == SYNC_BYTE) state_nxt = B2;
        B2:      state_nxt = B1;
        B1:      state_nxt = B0;
        default: state_nxt = HUNT;
      endcase
    end else if (timeout) begin
      state_nxt = HUNT;
    end
  end

  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) begin
      state          <= HUNT;
      hold           <= '0;
      gap            <= '0;
      link.data      <= '0;
      link.data_rdy  <= 1'b0;
      link.frame_err <= 1'b0;
      link.busy      <= 1'b0;
    end else begin
      state          <= state_nxt;
      link.busy      <= (state_nxt != HUNT);
      link.data_rdy  <= 1'b0;
      link.frame_err <= 1'b0;

      if (byte_err) begin
        link.frame_err <= (state != HUNT);
      end else if (byte_valid) begin
        case (state)
          B2: hold[15:8] <= byte_val;
          B1: hold[7:0]  <= byte_val;
          B0: begin
            link.data     <= {hold, byte_val};
            link.data_rdy <= 1'b1;
          end
          default: ;
        endcase
      end else if (timeout) begin
        link.frame_err <= 1'b1;
      end

      if (byte_valid)                  gap <= GW'(1);
      else if (state == HUNT)          gap <= '0;
      else if (rx_idle)                gap <= gap + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: table of test frames, hand-written
// timing corner cases and a randomized byte stream against a frame model.
module tb_uart_frame_rx;

  localparam int unsigned CPB  = 40;
  localparam logic [7:0]  SYNC = 8'h7B;

  logic clk_20m = 1'b0;
  logic rst_n;

  uart_frame_rx_if link();

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC), .TIMEOUT_BITS(20)) dut (
    .clk_20m(clk_20m),
    .rst_n  (rst_n),
    .link   (link)
  );

  always #25 clk_20m = ~clk_20m;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rdy_cnt     = 0;
  int err_cnt     = 0;
  int rdy_cyc     = 0;
  int err_cyc     = 0;
  int last_start  = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_front;

  always @(posedge clk_20m) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every data_rdy pulse must deliver the next word the model predicted.
  always @(negedge clk_20m) begin
    if (rst_n === 1'b1 && (link.data_rdy || link.frame_err)) begin
      vectors++;
      if (link.data_rdy && link.frame_err) begin
        miscompares++;
        $display("FAIL strobe_overlap: data_rdy and frame_err both high");
      end
    end
    if (rst_n === 1'b1 && link.data_rdy) begin
      rdy_cnt++;
      rdy_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rdy: got data %0h expected no strobe", link.data);
      end else begin
        exp_front = exp_q.pop_front();
        if (link.data !== exp_front) begin
          miscompares++;
          $display("FAIL rdy_data: got %0h expected %0h", link.data, exp_front);
        end
      end
    end
    if (rst_n === 1'b1 && link.frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic drive_bit(input logic b);
    @(posedge clk_20m);
    #1 link.rx = b;
    repeat (CPB - 1) @(posedge clk_20m);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // A bad stop bit is followed by one high bit so the line leaves the break.
  task automatic send_byte(input logic [7:0] v, input bit ok);
    @(posedge clk_20m);
    #1 link.rx = 1'b0;
    last_start = cyc;
    repeat (CPB - 1) @(posedge clk_20m);
    for (int i = 0; i < 8; i++) drive_bit(v[i]);
    drive_bit(ok);
    if (!ok) drive_bit(1'b1);
  endtask

  typedef struct {
    logic [63:0] b;
    int          n;
    logic [7:0]  bad;
    logic [23:0] exp_data;
    int          exp_rdy;
    int          exp_err;
  } row_t;

  typedef struct {
    logic [7:0] v;
    bit         ok;
    int         gap;
  } ev_t;

  row_t        rows[3];
  ev_t         evs[$];
  ev_t         ev;
  logic [63:0] bw;
  logic [23:0] pay;
  int          pos, exp_rdy, exp_err, r0, e0, s01;

  initial begin
    rows[0] = '{b: 64'h7B12345600000000, n: 4, bad: 8'h00, exp_data: 24'h123456, exp_rdy: 1, exp_err: 0};
    rows[1] = '{b: 64'h55AA7B7B007B0000, n: 6, bad: 8'h00, exp_data: 24'h7B007B, exp_rdy: 1, exp_err: 0};
    rows[2] = '{b: 64'h7B01337BDEADBE00, n: 7, bad: 8'h04, exp_data: 24'hDEADBE, exp_rdy: 1, exp_err: 1};

    rst_n   = 1'b0;
    link.rx = 1'b1;
    repeat (3) @(posedge clk_20m);
    #1;
    check("reset_data", link.data, 24'h0);
    check("reset_rdy", link.data_rdy, 1'b0);
    check("reset_err", link.frame_err, 1'b0);
    check("reset_busy", link.busy, 1'b0);
    rst_n = 1'b1;
    idle_bits(2);

    for (int r = 0; r < 3; r++) begin
      r0 = rdy_cnt;
      e0 = err_cnt;
      if (rows[r].exp_rdy != 0) exp_q.push_back(rows[r].exp_data);
      bw = rows[r].b;
      for (int i = 0; i < rows[r].n; i++) begin
        send_byte(bw[63 - 8*i -: 8], !rows[r].bad[i]);
        if (r == 0 && i == 0) check("busy_after_sync", link.busy, 1'b1);
      end
      idle_bits(2);
      check("row_rdy_count", rdy_cnt - r0, rows[r].exp_rdy);
      check("row_err_count", err_cnt - e0, rows[r].exp_err);
      check("row_data", link.data, rows[r].exp_data);
      check("row_busy_end", link.busy, 1'b0);
      check("row_rdy_latency", rdy_cyc - last_start, 384);
    end

    // Half-bit low glitch on an idle line.
    r0 = rdy_cnt;
    e0 = err_cnt;
    @(posedge clk_20m);
    #1 link.rx = 1'b0;
    repeat (20) @(posedge clk_20m);
    #1 link.rx = 1'b1;
    idle_bits(3);
    check("glitch_rdy", rdy_cnt - r0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_data", link.data, 24'hDEADBE);
    exp_q.push_back(24'h112233);
    send_byte(SYNC, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle_bits(2);
    check("glitch_then_frame", link.data, 24'h112233);

    // Inter-byte timeout.
    e0 = err_cnt;
    send_byte(SYNC, 1'b1);
    send_byte(8'h01, 1'b1);
    s01 = last_start;
    check("busy_mid_frame", link.busy, 1'b1);
    idle_bits(25);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_cycle", err_cyc - s01, 384 + 799);
    check("timeout_busy", link.busy, 1'b0);
    check("timeout_data_kept", link.data, 24'h112233);

    // Asynchronous reset between payload bytes.
    send_byte(SYNC, 1'b1);
    send_byte(8'hAB, 1'b1);
    check("busy_before_reset", link.busy, 1'b1);
    #10 rst_n = 1'b0;
    #1;
    check("midreset_data", link.data, 24'h0);
    check("midreset_busy", link.busy, 1'b0);
    check("midreset_rdy", link.data_rdy, 1'b0);
    check("midreset_err", link.frame_err, 1'b0);
    repeat (3) @(negedge clk_20m);
    rst_n = 1'b1;
    idle_bits(2);
    exp_q.push_back(24'hABCDEF);
    send_byte(SYNC, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
    idle_bits(2);
    check("post_reset_frame", link.data, 24'hABCDEF);

    // Random byte stream; the model scans it positionally.
    for (int i = 0; i < 48; i++) begin
      ev.v   = ($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom_range(0, 255));
      ev.ok  = ($urandom_range(0, 11) != 0);
      ev.gap = ($urandom_range(0, 9) == 0) ? 25 : int'($urandom_range(0, 3));
      if (i == 47) ev.gap = 25;
      evs.push_back(ev);
    end
    pos = 0;
    pay = '0;
    exp_rdy = 0;
    exp_err = 0;
    foreach (evs[i]) begin
      if (!evs[i].ok) begin
        if (pos != 0) exp_err++;
        pos = 0;
      end else if (pos == 0) begin
        if (evs[i].v == SYNC) begin
          pos = 1;
          pay = '0;
        end
      end else begin
        pay = 24'((pay << 8) | evs[i].v);
        pos++;
        if (pos == 4) begin
          exp_q.push_back(pay);
          exp_rdy++;
          pos = 0;
        end
      end
      if (pos != 0 && evs[i].gap >= 20) begin
        exp_err++;
        pos = 0;
      end
    end
    r0 = rdy_cnt;
    e0 = err_cnt;
    foreach (evs[i]) begin
      send_byte(evs[i].v, evs[i].ok);
      idle_bits(evs[i].gap);
    end
    check("rand_rdy_count", rdy_cnt - r0, exp_rdy);
    check("rand_err_count", err_cnt - e0, exp_err);
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_busy_end", link.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
